// File: rtl/fpu_rnd_pkg.sv
// Shared rounder-path types, default widths and
// the shift-level split used by the normaliser.
package fpu_rnd_pkg;

  localparam int FW_DEF  = 57;
  localparam int N_DEF   = 64;
  localparam int SHW_DEF = 13;

  typedef logic [2*N_DEF-1:0] fn_dw_t;

  // Levels in group s; earlier groups take the remainder.
  function automatic int lvl_cnt(int lv, int st, int s);
    return lv / st + ((s < lv % st) ? 1 : 0);
  endfunction

  // Index of the first level handled by group s.
  function automatic int lvl_first(int lv, int st, int s);
    return s * (lv / st) + ((s < lv % st) ? s : lv % st);
  endfunction

endpackage

// File: rtl/signorm_shift_stage.sv
// One registered group of log-shifter levels.
// Sticky carried only when SIGNORM_STICKY_EN is defined.
module signorm_shift_stage #(
  parameter int W2   = 128,
  parameter int LW   = 7,
  parameter int LO   = 0,
  parameter int NL   = 4,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [W2-1:0]   in_data,
  input  logic [LW-1:0]   in_amt,
  input  logic            in_rgt,
  input  logic            in_ovf,
`ifdef SIGNORM_STICKY_EN
  input  logic            in_sticky,
  output logic            out_sticky,
`endif
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  output logic [W2-1:0]   out_data,
  output logic [LW-1:0]   out_amt,
  output logic            out_rgt,
  output logic            out_ovf,
  output logic [TAGW-1:0] out_tag
);

  logic [W2-1:0] dn;
`ifdef SIGNORM_STICKY_EN
  logic sn;
`endif

  // Apply this group's levels; amt bit j selects 2^(LO+j).
  always_comb begin
    dn = in_data;
`ifdef SIGNORM_STICKY_EN
    sn = in_sticky;
`endif
    for (int j = 0; j < NL; j++) begin
      if (in_amt[j]) begin
        if (in_rgt) begin
`ifdef SIGNORM_STICKY_EN
          sn = sn | (|(dn & ~({W2{1'b1}} << (1 << (LO + j)))));
`endif
          dn = dn >> (1 << (LO + j));
        end else begin
          dn = dn << (1 << (LO + j));
        end
      end
    end
  end

  // Stage register; holds everything when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_amt    <= '0;
      out_rgt    <= 1'b0;
      out_ovf    <= 1'b0;
      out_tag    <= '0;
`ifdef SIGNORM_STICKY_EN
      out_sticky <= 1'b0;
`endif
    end else if (en) begin
      out_valid  <= in_valid;
      out_data   <= dn;
      out_amt    <= in_amt >> NL;
      out_rgt    <= in_rgt;
      out_ovf    <= in_ovf;
      out_tag    <= in_tag;
`ifdef SIGNORM_STICKY_EN
      out_sticky <= sn;
`endif
    end
  end

endmodule

// File: rtl/signorm_shift_pipe.sv
// Pipelined significand normalisation shifter, valid/ready.
// Optional sticky output: define SIGNORM_STICKY_EN.
module signorm_shift_pipe
  import fpu_rnd_pkg::*;
#(
  parameter int FW     = FW_DEF,
  parameter int N      = N_DEF,
  parameter int SHW    = SHW_DEF,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FW-1:0]   in_fr,
  input  logic [SHW-1:0]  in_sh,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_fn_hi,
  output logic [N-1:0]    out_fn_lo,
  output logic            out_ovf,
`ifdef SIGNORM_STICKY_EN
  output logic            out_sticky,
`endif
  output logic [TAGW-1:0] out_tag
);

  localparam int W2 = 2 * N;
  localparam int LW = $clog2(W2);

  logic            adv;
  logic [SHW-1:0]  mag;
  logic            rgt;
  logic            big;
  logic [W2-1:0]   w;

  logic [W2-1:0]   d [0:STAGES];
  logic [LW-1:0]   a [0:STAGES];
  logic            r [0:STAGES];
  logic            v [0:STAGES];
  logic            o [0:STAGES];
  logic [TAGW-1:0] t [0:STAGES];
`ifdef SIGNORM_STICKY_EN
  logic            k [0:STAGES];
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Range clamp and overflow are resolved ahead of group 0.
  assign w   = {in_fr, {(W2-FW){1'b0}}};
  assign rgt = in_sh[SHW-1];
  assign mag = rgt ? (~in_sh + 1'b1) : in_sh;
  assign big = mag > SHW'(W2 - 1);

  assign d[0] = big ? '0 : w;
  assign a[0] = big ? '0 : mag[LW-1:0];
  assign r[0] = rgt;
  assign v[0] = in_valid;
  assign t[0] = in_tag;
  assign o[0] = !rgt && (mag != '0) &&
                (big ? (|w) :
                 (|(w & ~({W2{1'b1}} >> mag[LW-1:0]))));
`ifdef SIGNORM_STICKY_EN
  assign k[0] = big && rgt && (|w);
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = lvl_first(LW, STAGES, s);
    localparam int NL = lvl_cnt(LW, STAGES, s);

    signorm_shift_stage #(
      .W2   (W2),
      .LW   (LW),
      .LO   (LO),
      .NL   (NL),
      .TAGW (TAGW)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (adv),
      .in_valid   (v[s]),
      .in_data    (d[s]),
      .in_amt     (a[s]),
      .in_rgt     (r[s]),
      .in_ovf     (o[s]),
`ifdef SIGNORM_STICKY_EN
      .in_sticky  (k[s]),
      .out_sticky (k[s+1]),
`endif
      .in_tag     (t[s]),
      .out_valid  (v[s+1]),
      .out_data   (d[s+1]),
      .out_amt    (a[s+1]),
      .out_rgt    (r[s+1]),
      .out_ovf    (o[s+1]),
      .out_tag    (t[s+1])
    );
  end

  assign out_valid  = v[STAGES];
  assign out_fn_hi  = d[STAGES][W2-1:N];
  assign out_fn_lo  = d[STAGES][N-1:0];
  assign out_ovf    = o[STAGES];
  assign out_tag    = t[STAGES];
`ifdef SIGNORM_STICKY_EN
  assign out_sticky = k[STAGES];
`endif

endmodule

// File: tb/tb_signorm_shift_pipe.sv
// Self-checking bench for signorm_shift_pipe.
// Reference: plain wide-integer shift of the fraction.
module tb_signorm_shift_pipe;
  import fpu_rnd_pkg::*;

  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        ovf;
    logic        st;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [56:0] in_fr = '0;
  logic [12:0] in_sh = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_fn_hi;
  logic [63:0] out_fn_lo;
  logic        out_ovf;
  logic [3:0]  out_tag;
  logic        sticky_o;

  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  signorm_shift_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fr      (in_fr),
    .in_sh      (in_sh),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fn_hi  (out_fn_hi),
    .out_fn_lo  (out_fn_lo),
    .out_ovf    (out_ovf),
`ifdef SIGNORM_STICKY_EN
    .out_sticky (sticky_o),
`endif
    .out_tag    (out_tag)
  );

`ifndef SIGNORM_STICKY_EN
  assign sticky_o = 1'b0;
`endif

  // Reference: shift the 128-bit window inside a 256-bit integer.
  function automatic exp_t model(logic [56:0] fr, logic [12:0] sh,
                                 logic [3:0] tag);
    exp_t   e;
    fn_dw_t w;
    logic [255:0] x;
    int s;
    w = {fr, 71'b0};
    s = $signed(sh);
    e = '0;
    e.tag = tag;
    if (s >= 128) begin
      e.ovf = |w;
    end else if (s >= 0) begin
      x = {128'b0, w} << s;
      {e.hi, e.lo} = x[127:0];
      e.ovf = |x[255:128];
    end else if (-s >= 128) begin
      e.st = |w;
    end else begin
      x = {w, 128'b0} >> (-s);
      {e.hi, e.lo} = x[255:128];
      e.st = |x[127:0];
    end
`ifndef SIGNORM_STICKY_EN
    e.st = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [12:0] rand_sh();
    int v;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: v = int'($urandom_range(0, 280)) - 140;
      6, 7:             v = int'($urandom_range(0, 8191));
      default: begin
        case ($urandom_range(0, 6))
          0: v = -128;
          1: v = -127;
          2: v = 127;
          3: v = 128;
          4: v = 0;
          5: v = -64;
          default: v = 64;
        endcase
      end
    endcase
    return v[12:0];
  endfunction

  function automatic logic [56:0] rand_fr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 9) == 0) r = '0;
    return r[56:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #3;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_fn_hi !== 64'h0 || out_fn_lo !== 64'h0 ||
        out_ovf !== 1'b0 || out_tag !== 4'h0 || sticky_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: v=%b rdy=%b hi=%h lo=%h ovf=%b tag=%h st=%b",
               out_valid, in_ready, out_fn_hi, out_fn_lo, out_ovf,
               out_tag, sticky_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int          shv [8] = '{0, -1, -64, -128, 1, -127, -200, 5};
    logic [63:0] eh  [8] = '{64'h8000_0000_0000_0000,
                             64'h4000_0000_0000_0000,
                             64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] el  [8] = '{64'h0, 64'h0, 64'h8000_0000_0000_0000,
                             64'h0, 64'h0, 64'h1, 64'h0, 64'h0};
    logic        eo  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic        es  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    logic [56:0] one56;
    int lat;
    one56 = 57'd1 << 56;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_fr = (i < 6) ? one56 : 57'd0;
      in_sh = shv[i][12:0];
      in_tag = i[3:0];
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat++;
      end while (!out_valid && lat < 10);
      vectors++;
      if (lat != 2) begin
        miscompares++;
        $display("FAIL dir_latency[%0d]: got %0d exp 2", i, lat);
      end
      vectors++;
      if (out_fn_hi !== eh[i] || out_fn_lo !== el[i] ||
          out_ovf !== eo[i] || out_tag !== i[3:0]) begin
        miscompares++;
        $display("FAIL dir_data[%0d] sh=%0d: hi=%h lo=%h ovf=%b tag=%h exp hi=%h lo=%h ovf=%b",
                 i, shv[i], out_fn_hi, out_fn_lo, out_ovf, out_tag,
                 eh[i], el[i], eo[i]);
      end
`ifdef SIGNORM_STICKY_EN
      vectors++;
      if (sticky_o !== es[i]) begin
        miscompares++;
        $display("FAIL dir_sticky[%0d]: got %b exp %b", i, sticky_o, es[i]);
      end
`else
      if (es[i] && sticky_o) $display("note: sticky absent");
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got = 0;
    logic stall;
    logic pstall = 1'b0;
    logic [131:0] prev = '0;
    exp_t e;
    for (int c = 0; c < 80 && !(sent == 12 && q.size() == 0); c++) begin
      stall = (c >= 5 && c < 8);
      out_ready = !stall;
      in_valid = (sent < 12);
      in_fr = rand_fr();
      in_sh = rand_sh();
      in_tag = sent[3:0];
      #1;
      if (stall) begin
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_stall c=%0d: in_ready=%b out_valid=%b exp 0/1",
                   c, in_ready, out_valid);
        end
        if (pstall) begin
          vectors++;
          if ({out_fn_hi, out_fn_lo, out_tag} !== prev) begin
            miscompares++;
            $display("FAIL b2b_hold c=%0d: got %h exp %h", c,
                     {out_fn_hi, out_fn_lo, out_tag}, prev);
          end
        end
        prev = {out_fn_hi, out_fn_lo, out_tag};
      end
      pstall = stall;
      if (in_valid && in_ready) begin
        q.push_back(model(in_fr, in_sh, in_tag));
        sent++;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra: tag=%h got, none exp", out_tag);
        end else begin
          e = q.pop_front();
          got++;
          if (out_fn_hi !== e.hi || out_fn_lo !== e.lo ||
              out_ovf !== e.ovf || out_tag !== e.tag || sticky_o !== e.st) begin
            miscompares++;
            $display("FAIL b2b_data: got %h %h %b %b %h exp %h %h %b %b %h",
                     out_fn_hi, out_fn_lo, out_ovf, sticky_o, out_tag,
                     e.hi, e.lo, e.ovf, e.st, e.tag);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 12 || q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d beats, %0d pending, exp 12/0",
               got, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_fr = rand_fr() | 57'd1;
      in_sh = 13'd0;
      in_tag = 4'(i + 9);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: out_valid=%b exp 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_fn_hi !== 64'h0 || out_tag !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_async: v=%b hi=%h tag=%h exp 0",
               out_valid, out_fn_hi, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_stale c=%0d: out_valid=%b exp 0", c, out_valid);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 620; c++) begin
      in_valid = (c < 600) && ($urandom_range(0, 9) < 7);
      out_ready = (c >= 600) || ($urandom_range(0, 9) < 7);
      in_fr = rand_fr();
      in_sh = rand_sh();
      in_tag = 4'($urandom_range(0, 15));
      #1;
      if (in_valid && in_ready) q.push_back(model(in_fr, in_sh, in_tag));
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra: tag=%h got, none exp", out_tag);
        end else begin
          e = q.pop_front();
          if (out_fn_hi !== e.hi || out_fn_lo !== e.lo ||
              out_ovf !== e.ovf || out_tag !== e.tag || sticky_o !== e.st) begin
            miscompares++;
            $display("FAIL rand_data c=%0d: got %h %h %b %b %h exp %h %h %b %b %h",
                     c, out_fn_hi, out_fn_lo, out_ovf, sticky_o, out_tag,
                     e.hi, e.lo, e.ovf, e.st, e.tag);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_drain: %0d pending, out_valid=%b exp 0/0",
               q.size(), out_valid);
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
